// File: rtl/alu_pkg.sv
// Shared opcode constants, request bundle and opcode helper for the
// ALU issue path.
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [2:0]       op;
    } alu_req_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) ||
               (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundle of request, ALU and result signals around the issue stage.
// slave is the stage's view; master is the surrounding pipeline's view.
interface alu_issue_stage_if #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic [W-1:0]           in_a;
    logic [W-1:0]           in_b;
    logic [2:0]             in_op;

    logic [W-1:0]           alu_a;
    logic [W-1:0]           alu_b;
    logic [2:0]             alu_op;
    logic [W-1:0]           alu_z;
    logic                   alu_ex;

    logic                   out_valid;
    logic                   out_ready;
    logic [W-1:0]           out_z;
    logic                   out_ex;
    logic [2:0]             out_op;

    logic [$clog2(DEPTH):0] count;

    modport slave (
        input  in_valid, in_a, in_b, in_op,
        input  alu_z, alu_ex, out_ready,
        output in_ready, alu_a, alu_b, alu_op,
        output out_valid, out_z, out_ex, out_op, count
    );

    modport master (
        output in_valid, in_a, in_b, in_op,
        output alu_z, alu_ex, out_ready,
        input  in_ready, alu_a, alu_b, alu_op,
        input  out_valid, out_z, out_ex, out_op, count
    );

endinterface

// File: rtl/alu_req_fifo.sv
// Request FIFO with separate occupancy counter; head reads as zero
// while empty. Caller guarantees no push when full, no pop when empty.
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 67
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DW-1:0]          push_data,
    input  logic                   pop,
    output logic [DW-1:0]          head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    // Storage write at the tail; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers wrap naturally; count disambiguates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Empty FIFO presents zeros so the ALU sees quiet operands.
    always_comb begin
        head = '0;
        if (count != '0) begin
            head = mem[rptr];
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage feeding a combinational ALU and registering its result.
// Optional ALU_ILLEGAL_OP_TRAP_EN traps opcodes the ALU does not define.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ALU_W
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_stage_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = $bits(alu_req_t);

    alu_req_t      req_in;
    alu_req_t      head;
    logic [DW-1:0] head_bits;
    logic          push;
    logic          issue;
    logic          head_legal;
    logic [W-1:0]  cap_z;
    logic          cap_ex;

    assign req_in = '{a: bus.in_a, b: bus.in_b, op: bus.in_op};

    // Acceptance depends only on stored occupancy, never on out_ready.
    assign bus.in_ready = (bus.count != CW'(DEPTH));
    assign push         = bus.in_valid & bus.in_ready;

    // Issue when a request is queued and the result slot is free
    // or being emptied this cycle.
    assign issue = (bus.count != '0) &
                   (!bus.out_valid | bus.out_ready);

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (req_in),
        .pop       (issue),
        .head      (head_bits),
        .count     (bus.count)
    );

    assign head = alu_req_t'(head_bits);

`ifdef ALU_ILLEGAL_OP_TRAP_EN
    assign head_legal = is_legal_op(head.op);
`else
    assign head_legal = 1'b1;
`endif

    // Undefined opcodes reach the ALU as AND and are overridden at capture.
    assign bus.alu_a  = head.a;
    assign bus.alu_b  = head.b;
    assign bus.alu_op = head_legal ? head.op : OP_AND;

    assign cap_z  = head_legal ? bus.alu_z  : '0;
    assign cap_ex = head_legal ? bus.alu_ex : 1'b1;

    // Result register: load on issue, clear valid when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_z     <= '0;
            bus.out_ex    <= 1'b0;
            bus.out_op    <= OP_AND;
        end else if (issue) begin
            bus.out_valid <= 1'b1;
            bus.out_z     <= cap_z;
            bus.out_ex    <= cap_ex;
            bus.out_op    <= head.op;
        end else if (bus.out_valid & bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU model.
// Honours ALU_ILLEGAL_OP_TRAP_EN when checking undefined opcodes.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    alu_issue_stage_if #(.W(32), .DEPTH(4)) bus ();

    alu_issue_stage #(.DEPTH(4), .W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [32:0] alu_ref(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [2:0]  op);
        case (op)
            3'b000:  return {1'b0, a & b};
            3'b001:  return {1'b0, a | b};
            3'b010:  return {1'b0, a} + {1'b0, b};
            3'b110:  return {a < b, a - b};
            default: return {1'b0, 32'hDEAD_0000 | a};
        endcase
    endfunction

    assign {bus.alu_ex, bus.alu_z} = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

    logic [31:0] bp_a   [5] = '{32'd10, 32'hF0, 32'd1, 32'd1, 32'd2};
    logic [31:0] bp_b   [5] = '{32'd3, 32'h3C, 32'd2, 32'd1, 32'd2};
    logic [2:0]  bp_op  [5] = '{3'b110, 3'b000, 3'b001, 3'b010, 3'b010};
    logic [31:0] bp_res [5] = '{32'd7, 32'h30, 32'd3, 32'd2, 32'd4};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
    endtask

    task automatic fill_bp(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, bp_a[i], bp_b[i], bp_op[i]);
            tick();
        end
        drive(1'b0, 32'd0, 32'd0, 3'b000);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 3'b000);
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
            $display("FAIL reset_state count=%0d valid=%b want 0/0",
                     bus.count, bus.out_valid);
        end else passed++;
        total++;
        if (bus.out_z !== 32'd0 || bus.out_ex !== 1'b0 || bus.out_op !== 3'd0) begin
            $display("FAIL reset_result z=%h ex=%b op=%b want 0/0/000",
                     bus.out_z, bus.out_ex, bus.out_op);
        end else passed++;
        total++;
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end else passed++;
        total++;
        if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.alu_op !== 3'd0) begin
            $display("FAIL reset_alu_drive a=%h b=%h op=%b want zeros",
                     bus.alu_a, bus.alu_b, bus.alu_op);
        end else passed++;
    endtask

    task automatic test_single_add;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'd5, 32'd7, 3'b010);
        tick();
        drive(1'b0, 32'd0, 32'd0, 3'b000);
        total++;
        if (bus.count !== 3'd1 || bus.out_valid !== 1'b0 ||
            bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7) begin
            $display("FAIL add_head count=%0d valid=%b a=%h b=%h want 1/0/5/7",
                     bus.count, bus.out_valid, bus.alu_a, bus.alu_b);
        end else passed++;
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_z !== 32'd12 ||
            bus.out_ex !== 1'b0 || bus.out_op !== 3'b010 || bus.count !== 3'd0) begin
            $display("FAIL add_result v=%b z=%h ex=%b op=%b cnt=%0d want 1/c/0/010/0",
                     bus.out_valid, bus.out_z, bus.out_ex, bus.out_op, bus.count);
        end else passed++;
        tick();
        total++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL add_drain valid=%b want 0", bus.out_valid);
        end else passed++;
    endtask

    task automatic test_backpressure;
        bus.out_ready = 1'b0;
        fill_bp(5);
        total++;
        if (bus.count !== 3'd4 || bus.in_ready !== 1'b0 ||
            bus.out_valid !== 1'b1 || bus.out_z !== 32'd7) begin
            $display("FAIL bp_full cnt=%0d rdy=%b v=%b z=%h want 4/0/1/7",
                     bus.count, bus.in_ready, bus.out_valid, bus.out_z);
        end else passed++;
        tick();
        total++;
        if (bus.out_z !== 32'd7 || bus.out_op !== 3'b110 || bus.count !== 3'd4) begin
            $display("FAIL bp_hold z=%h op=%b cnt=%0d want 7/110/4",
                     bus.out_z, bus.out_op, bus.count);
        end else passed++;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_z !== bp_res[i] ||
                bus.out_op !== bp_op[i]) begin
                $display("FAIL bp_order[%0d] v=%b z=%h op=%b want 1/%h/%b",
                         i, bus.out_valid, bus.out_z, bus.out_op, bp_res[i], bp_op[i]);
            end else passed++;
            tick();
        end
        total++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
            $display("FAIL bp_empty v=%b cnt=%0d want 0/0", bus.out_valid, bus.count);
        end else passed++;
    endtask

    task automatic test_full_pop;
        bus.out_ready = 1'b0;
        fill_bp(5);
        drive(1'b1, 32'd100, 32'd100, 3'b010);
        bus.out_ready = 1'b1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            $display("FAIL full_refuse in_ready=%b want 0", bus.in_ready);
        end else passed++;
        tick();
        drive(1'b0, 32'd0, 32'd0, 3'b000);
        total++;
        if (bus.count !== 3'd3 || bus.in_ready !== 1'b1 || bus.out_z !== 32'h30) begin
            $display("FAIL full_pop cnt=%0d rdy=%b z=%h want 3/1/30",
                     bus.count, bus.in_ready, bus.out_z);
        end else passed++;
        for (int i = 2; i < 5; i++) begin
            tick();
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_z !== bp_res[i]) begin
                $display("FAIL full_drain[%0d] v=%b z=%h want 1/%h",
                         i, bus.out_valid, bus.out_z, bp_res[i]);
            end else passed++;
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
            $display("FAIL full_no_extra v=%b z=%h cnt=%0d want 0/-/0",
                     bus.out_valid, bus.out_z, bus.count);
        end else passed++;
    endtask

    task automatic test_streaming;
        logic [31:0] sa [16];
        logic [31:0] sb [16];
        logic [2:0]  so [16];
        logic [32:0] exp_r;
        logic [2:0]  optab [4];
        optab = '{3'b000, 3'b001, 3'b010, 3'b110};
        for (int i = 0; i < 16; i++) begin
            sa[i] = $urandom;
            sb[i] = $urandom;
            so[i] = optab[$urandom_range(0, 3)];
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) drive(1'b1, sa[k], sb[k], so[k]);
            else        drive(1'b0, 32'd0, 32'd0, 3'b000);
            tick();
            if (k >= 1) begin
                exp_r = alu_ref(sa[k-1], sb[k-1], so[k-1]);
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_z !== exp_r[31:0] ||
                    bus.out_ex !== exp_r[32] || bus.out_op !== so[k-1]) begin
                    $display("FAIL stream[%0d] v=%b z=%h ex=%b op=%b want 1/%h/%b/%b",
                             k-1, bus.out_valid, bus.out_z, bus.out_ex, bus.out_op,
                             exp_r[31:0], exp_r[32], so[k-1]);
                end else passed++;
            end
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
            $display("FAIL stream_end v=%b cnt=%0d want 0/0", bus.out_valid, bus.count);
        end else passed++;
    endtask

    task automatic test_reset_mid;
        bus.out_ready = 1'b0;
        fill_bp(4);
        total++;
        if (bus.count !== 3'd3 || bus.out_valid !== 1'b1) begin
            $display("FAIL rmid_pre cnt=%0d v=%b want 3/1", bus.count, bus.out_valid);
        end else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 ||
            bus.out_z !== 32'd0 || bus.in_ready !== 1'b1) begin
            $display("FAIL rmid_post cnt=%0d v=%b z=%h rdy=%b want 0/0/0/1",
                     bus.count, bus.out_valid, bus.out_z, bus.in_ready);
        end else passed++;
        bus.out_ready = 1'b1;
        tick();
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
            $display("FAIL rmid_stale v=%b cnt=%0d want 0/0", bus.out_valid, bus.count);
        end else passed++;
    endtask

    task automatic test_illegal_op;
        logic [2:0]  exp_alu_op;
        logic [31:0] exp_z;
        logic        exp_ex;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
        exp_alu_op = 3'b000;
        exp_z      = 32'd0;
        exp_ex     = 1'b1;
`else
        exp_alu_op = 3'b011;
        exp_z      = 32'hDEAD_0001;
        exp_ex     = 1'b0;
`endif
        bus.out_ready = 1'b1;
        drive(1'b1, 32'd1, 32'd1, 3'b011);
        tick();
        drive(1'b0, 32'd0, 32'd0, 3'b000);
        total++;
        if (bus.alu_op !== exp_alu_op) begin
            $display("FAIL illegal_alu_op got %b want %b", bus.alu_op, exp_alu_op);
        end else passed++;
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_z !== exp_z ||
            bus.out_ex !== exp_ex || bus.out_op !== 3'b011) begin
            $display("FAIL illegal_result v=%b z=%h ex=%b op=%b want 1/%h/%b/011",
                     bus.out_valid, bus.out_z, bus.out_ex, bus.out_op, exp_z, exp_ex);
        end else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_backpressure();
        test_full_pop();
        test_streaming();
        test_reset_mid();
        test_illegal_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand/opcode issue stage directly upstream of the 32-bit combinational ALU (ops AND/OR/ADD/SUB, outputs z and ex).
- Buffers incoming (a, b, op) requests in a FIFO and presents the head entry to the ALU.
- Captures z/ex into a result register and hands results downstream over a valid/ready handshake.
- Decouples the producer, for example a decode or register-read stage, from the consumer, for example writeback.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- W, 32, operand and result width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  FIFO can accept a request.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_op  in  3  opcode: 000 AND, 001 OR, 010 ADD, 110 SUB.
- alu_a  out  W  operand A to ALU.
- alu_b  out  W  operand B to ALU.
- alu_op  out  3  opcode to ALU.
- alu_z  in  W  ALU result, combinational from alu_a/alu_b/alu_op.
- alu_ex  in  1  ALU exception/flag output.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  downstream accepts the result.
- out_z  out  W  registered result.
- out_ex  out  1  registered ex.
- out_op  out  3  opcode that produced the result.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset is synchronous and active-high, on rst at the clk edge.
  - Reset state: FIFO empty; count=0; out_valid=0; out_z=0; out_ex=0; out_op=000.
  - Reset state: in_ready=1 in the cycle after reset.
  - alu_a/alu_b/alu_op are 0 while the FIFO is empty.
- Reset mid-operation discards all queued entries and any held result; no partial output.
- Push: on in_valid & in_ready at an edge, write {in_a, in_b, in_op} at the tail.
- in_ready = (count != DEPTH).
  - in_ready is registered-state only, with no combinational path from out_ready.
  - A full FIFO therefore refuses a push even if a pop happens in the same cycle.
- ALU drive: alu_a/alu_b/alu_op come combinationally from the FIFO head.
  - They are 0 when the FIFO is empty.
- Issue: issue = (count != 0) & (!out_valid | out_ready).
  - On issue at an edge: out_z <= alu_z, out_ex <= alu_ex, out_op <= head op, out_valid <= 1, pop head.
- Drain: out_valid clears when out_valid & out_ready & !issue.
- Throughput: one result per cycle when out_ready is held high.
- Latency: a request accepted into an empty FIFO at edge N issues at edge N+1.
  - out_valid is high in the cycle after edge N+1, i.e. 2 cycles from acceptance.
- Simultaneous push and pop: count unchanged; the pushed entry goes behind the popped one.
- Push into an empty FIFO is not visible at the head until the next cycle (no bypass).
- Pointers: wrap modulo DEPTH. count is tracked separately, so full and empty are unambiguous.
- Backpressure: while out_valid & !out_ready, out_z/out_ex/out_op hold stable and the FIFO keeps filling.
- Order: strictly FIFO; results leave in acceptance order.

Optional Feature:
- Macro: ALU_ILLEGAL_OP_TRAP_EN.
- When defined:
  - An opcode outside {000, 001, 010, 110} is still accepted and issued.
  - At capture: out_z <= 0 and out_ex <= 1, ignoring alu_z/alu_ex.
  - alu_op is driven as 000 for that entry.
- When undefined: every opcode passes to the ALU unmodified and alu_z/alu_ex are captured as-is.

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b110.
  - typedef alu_req_t = packed struct {a, b, op}.
  - function is_legal_op.
- One sub-module: alu_req_fifo.
  - Parameterised on DEPTH and the alu_req_t width.
  - Provides push/pop/count.
- The issue/result register logic stays in alu_issue_stage.

Test Plan:
- Single ADD, FIFO empty, out_ready=1:
  - a=5, b=7, op=010 accepted at edge N.
  - out_valid=1 after edge N+1 with out_z=12, out_ex from ALU, out_op=010; count back to 0.
- Backpressure fill, out_ready=0, DEPTH=4:
  - push 5 back-to-back requests (SUB 10,3; AND F0,3C; OR 1,2; ADD 1,1; ADD 2,2).
  - First issues into the result register; 4 queue; in_ready=0 with count=4.
  - Raise out_ready: results emerge in order 7, 0x30, 3, 2, 4.
- Full with simultaneous pop:
  - count=4, out_valid=1, out_ready=1, in_valid=1.
  - Push refused (in_ready=0); count goes to 3; next cycle in_ready=1.
- Streaming:
  - 16 random ADD/SUB/AND/OR requests with in_valid and out_ready held high.
  - One result per cycle after a 2-cycle fill; each out_z matches the software model; order preserved.
- Reset mid-operation:
  - count=3 and out_valid=1; assert rst for one cycle.
  - Next cycle: count=0, out_valid=0, out_z=0, in_ready=1; no stale results after release.
- Illegal op 011, a=1, b=1:
  - With ALU_ILLEGAL_OP_TRAP_EN: out_z=0, out_ex=1.
  - Without it: out_z/out_ex equal the ALU outputs for op=011.
